// File: rtl/oddr_word_serializer_pkg.sv
// Shared types and constants for the DDR word serializer and its companions.
package oddr_word_serializer_pkg;

  // Width of the LEAD/TAIL idle-cycle counter (covers 0..15).
  localparam int CNT_W = 4;

  // Serializer FSM state encodings.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

endpackage

// File: rtl/oddr_word_serializer_word_hold_reg.sv
// One-entry hold register with valid/ready on the input side and a load
// strobe from the consumer that empties it.
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             dvalid,
  input  logic             load,
  output logic             dready,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  logic accept;

  // Ready is suppressed during reset so nothing is taken while the consumer restarts.
  assign dready = !full && !rst;
  assign accept = dvalid && dready;

  // Occupancy flag: set by an accept, cleared by a load; both never coincide.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end else if (load) begin
      full <= 1'b0;
    end
  end

  // Data storage, written only on accept.
  always_ff @(posedge clk) begin
    // NOTE: the data word is deliberately not reset; the full flag alone qualifies it.
    if (accept) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/oddr_word_serializer.sv
// Parallel-to-DDR serializer: emits two bits per clock (MSB first) and drives
// the CE/T controls of the downstream DDR flop and tristate pad driver.
module oddr_word_serializer
  import oddr_word_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEAD  = 1,
  parameter int TAIL  = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             D0,
  output logic             D1,
  output logic             CE,
  output logic             T,
  output logic             BUSY
);

  localparam int BEATS  = WIDTH / 2;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  LEAD_LAST = CNT_W'((LEAD > 0) ? LEAD - 1 : 0);
  localparam logic [CNT_W-1:0]  TAIL_LAST = CNT_W'((TAIL > 0) ? TAIL - 1 : 0);

  state_t             state, state_nx;
  logic [BEAT_W-1:0]  beat, beat_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [WIDTH-1:0]   shifter, shift_nx;
  logic [WIDTH-1:0]   hold_data;
  logic               hold_full;
  logic               load;
  logic               d0_nx, d1_nx, t_nx;

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (C),
    .rst    (R),
    .din    (DIN),
    .dvalid (DVALID),
    .load   (load),
    .dready (DREADY),
    .full   (hold_full),
    .dout   (hold_data)
  );

  // Next-state, counter and shifter logic; outputs are derived from the next state.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nx = state;
    beat_nx  = beat;
    cnt_nx   = cnt;
    shift_nx = shifter;
    load     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          if (LEAD > 0) begin
            state_nx = ST_LEAD;
            cnt_nx   = '0;
          end else begin
            state_nx = ST_SHIFT;
            load     = 1'b1;
          end
        end
      end
      ST_LEAD: begin
        if (cnt == LEAD_LAST) begin
          state_nx = ST_SHIFT;
          load     = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (beat == BEAT_LAST) begin
          // A word already held continues the burst gaplessly; a word
          // arriving on this very edge goes through TAIL (or IDLE) first.
          if (hold_full) begin
            load = 1'b1;
          end else if (TAIL > 0) begin
            state_nx = ST_TAIL;
            cnt_nx   = '0;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          beat_nx  = beat + BEAT_W'(1);
          shift_nx = {shifter[WIDTH-3:0], 2'b00};
        end
      end
      ST_TAIL: begin
        if (hold_full) begin
          state_nx = ST_SHIFT;
          load     = 1'b1;
        end else if (cnt == TAIL_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (load) begin
      shift_nx = hold_data;
      beat_nx  = '0;
    end

    t_nx  = (state_nx == ST_IDLE);
    d0_nx = (state_nx == ST_SHIFT) ? shift_nx[WIDTH-1] : 1'b0;
    d1_nx = (state_nx == ST_SHIFT) ? shift_nx[WIDTH-2] : 1'b0;
  end

  // State, counters, shifter and registered pad-side outputs.
  always_ff @(posedge C) begin
    if (R) begin
      state   <= ST_IDLE;
      beat    <= '0;
      cnt     <= '0;
      shifter <= '0;
      D0      <= 1'b0;
      D1      <= 1'b0;
      CE      <= 1'b0;
      T       <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nx;
      beat    <= beat_nx;
      cnt     <= cnt_nx;
      shifter <= shift_nx;
      D0      <= d0_nx;
      D1      <= d1_nx;
      CE      <= !t_nx;
      T       <= t_nx;
      BUSY    <= !t_nx;
    end
  end

endmodule

// File: tb/tb_oddr_word_serializer.sv
// Directed bench: dut_a uses LEAD=1/TAIL=1, dut_b uses LEAD=0/TAIL=0.
// Output snapshots are packed as {T, CE, D0, D1}; BUSY is checked as !T.
module tb_oddr_word_serializer;

  logic       c = 1'b0;
  logic       r;
  logic [7:0] a_din, b_din;
  logic       a_dvalid, b_dvalid;
  logic       a_dready, a_d0, a_d1, a_ce, a_t, a_busy;
  logic       b_dready, b_d0, b_d1, b_ce, b_t, b_busy;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] IDLE = 4'b1000;
  localparam logic [3:0] ZERO = 4'b0100;
  localparam logic [3:0] P00  = 4'b0100;
  localparam logic [3:0] P01  = 4'b0101;
  localparam logic [3:0] P10  = 4'b0110;
  localparam logic [3:0] P11  = 4'b0111;

  always #5 c = ~c;

  oddr_word_serializer #(.WIDTH(8), .LEAD(1), .TAIL(1)) dut_a (
    .C(c), .R(r), .DIN(a_din), .DVALID(a_dvalid), .DREADY(a_dready),
    .D0(a_d0), .D1(a_d1), .CE(a_ce), .T(a_t), .BUSY(a_busy)
  );

  oddr_word_serializer #(.WIDTH(8), .LEAD(0), .TAIL(0)) dut_b (
    .C(c), .R(r), .DIN(b_din), .DVALID(b_dvalid), .DREADY(b_dready),
    .D0(b_d0), .D1(b_d1), .CE(b_ce), .T(b_t), .BUSY(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  function automatic logic [4:0] obs_a();
    return {a_t, a_ce, a_d0, a_d1, a_busy};
  endfunction

  function automatic logic [4:0] obs_b();
    return {b_t, b_ce, b_d0, b_d1, b_busy};
  endfunction

  task automatic step_a(input string tag, input logic [3:0] exp4);
    tick();
    check(tag, 32'(obs_a()), 32'({exp4, !exp4[3]}));
  endtask

  task automatic step_b(input string tag, input logic [3:0] exp4);
    tick();
    check(tag, 32'(obs_b()), 32'({exp4, !exp4[3]}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] bp_w [4];
    logic [7:0] asm_w;
    logic       acc, prev_rdy;
    int         idx, acc_n, rises;

    r = 1'b1;
    a_din = '0; b_din = '0;
    a_dvalid = 1'b0; b_dvalid = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_out_a", 32'(obs_a()), 32'({IDLE, 1'b0}));
    check("rst_out_b", 32'(obs_b()), 32'({IDLE, 1'b0}));
    check("rst_dready", 32'(a_dready), 32'd0);
    r = 1'b0;
    #1;
    check("post_rst_dready", 32'(a_dready), 32'd1);

    // Single word 0xB4
    a_din = 8'hB4; a_dvalid = 1'b1;
    tick();
    a_dvalid = 1'b0;
    check("sw_dready_full", 32'(a_dready), 32'd0);
    check("sw_accept_edge", 32'(obs_a()), 32'({IDLE, 1'b0}));
    step_a("sw_lead", ZERO);
    step_a("sw_p0", P10);
    check("sw_dready_after_load", 32'(a_dready), 32'd1);
    step_a("sw_p1", P11);
    step_a("sw_p2", P01);
    step_a("sw_p3", P00);
    step_a("sw_tail", ZERO);
    step_a("sw_idle", IDLE);

    // Back-to-back 0xFF then 0x00, second offered during beat 0
    a_din = 8'hFF; a_dvalid = 1'b1;
    tick();
    a_dvalid = 1'b0;
    step_a("b2b_lead", ZERO);
    step_a("b2b_w0p0", P11);
    a_din = 8'h00; a_dvalid = 1'b1;
    step_a("b2b_w0p1", P11);
    a_dvalid = 1'b0;
    step_a("b2b_w0p2", P11);
    step_a("b2b_w0p3", P11);
    for (int i = 0; i < 4; i++) step_a($sformatf("b2b_w1p%0d", i), P00);
    step_a("b2b_tail", ZERO);
    step_a("b2b_idle", IDLE);

    // Late word: 0xC3 accepted on the last-beat edge of 0x5A
    a_din = 8'h5A; a_dvalid = 1'b1;
    tick();
    a_dvalid = 1'b0;
    step_a("late_lead", ZERO);
    step_a("late_w0p0", P01);
    step_a("late_w0p1", P01);
    step_a("late_w0p2", P10);
    step_a("late_w0p3", P10);
    a_din = 8'hC3; a_dvalid = 1'b1;
    step_a("late_gap", ZERO);
    a_dvalid = 1'b0;
    step_a("late_w1p0", P11);
    step_a("late_w1p1", P00);
    step_a("late_w1p2", P00);
    step_a("late_w1p3", P11);
    step_a("late_tail", ZERO);
    step_a("late_idle", IDLE);

    // Backpressure: DVALID held with four words
    bp_w[0] = 8'h1B; bp_w[1] = 8'hE4; bp_w[2] = 8'h72; bp_w[3] = 8'h8D;
    idx = 0; acc_n = 0; rises = 0; asm_w = '0;
    a_din = bp_w[0]; a_dvalid = 1'b1;
    prev_rdy = a_dready;
    for (int e = 0; e < 20; e++) begin
      acc = a_dvalid && a_dready;
      tick();
      if (acc) begin
        idx++;
        acc_n++;
        if (idx < 4) a_din = bp_w[idx];
        else a_dvalid = 1'b0;
      end
      if (a_dready && !prev_rdy) rises++;
      prev_rdy = a_dready;
      if (e == 1) check("bp_lead", 32'(obs_a()), 32'({ZERO, 1'b1}));
      if (e >= 2 && e <= 17) begin
        asm_w = {asm_w[5:0], a_d0, a_d1};
        if ((e - 2) % 4 == 3)
          check($sformatf("bp_word%0d", (e - 2) / 4), 32'(asm_w), 32'(bp_w[(e - 2) / 4]));
      end
      if (e == 18) check("bp_tail", 32'(obs_a()), 32'({ZERO, 1'b1}));
      if (e == 19) check("bp_idle", 32'(obs_a()), 32'({IDLE, 1'b0}));
    end
    check("bp_accepts", 32'(acc_n), 32'd4);
    check("bp_ready_rises", 32'(rises), 32'd4);

    // Reset mid-burst on beat 2 of 0xA5, with 0x77 held
    a_din = 8'hA5; a_dvalid = 1'b1;
    tick();
    a_dvalid = 1'b0;
    step_a("rmb_lead", ZERO);
    step_a("rmb_p0", P10);
    a_din = 8'h77; a_dvalid = 1'b1;
    step_a("rmb_p1", P10);
    a_dvalid = 1'b0;
    step_a("rmb_p2", P01);
    r = 1'b1;
    a_din = 8'h99; a_dvalid = 1'b1;
    tick();
    check("rmb_reset_out", 32'(obs_a()), 32'({IDLE, 1'b0}));
    check("rmb_reset_dready", 32'(a_dready), 32'd0);
    r = 1'b0; a_dvalid = 1'b0;
    #1;
    check("rmb_hold_cleared", 32'(a_dready), 32'd1);
    step_a("rmb_stays_idle", IDLE);
    a_din = 8'hC3; a_dvalid = 1'b1;
    tick();
    a_dvalid = 1'b0;
    step_a("rmb_fresh_lead", ZERO);
    step_a("rmb_fresh_p0", P11);
    repeat (5) tick();
    check("rmb_end_idle", 32'(obs_a()), 32'({IDLE, 1'b0}));

    // Zero lead/tail: 0x96 on dut_b
    b_din = 8'h96; b_dvalid = 1'b1;
    tick();
    b_dvalid = 1'b0;
    step_b("zlt_p0", P10);
    step_b("zlt_p1", P01);
    step_b("zlt_p2", P01);
    step_b("zlt_p3", P10);
    step_b("zlt_release", IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oddr_word_serializer.md
# oddr_word_serializer

Parallel-to-DDR serializer: accepts WIDTH-bit words over a valid/ready handshake and emits two bits per clock on D0/D1. It also drives the CE and T controls of the DDR output flop with tristate buffer that sits directly downstream, turning the pad driver on before a burst and releasing it after. All outputs are registered, so they can feed the DDR flop inputs directly.

## Interface
Parameters:
- WIDTH, 8: word width in bits; even, ≥4.
- LEAD, 1: driven-idle cycles before the first data pair of a burst; 0..15.
- TAIL, 1: driven-idle cycles after the last data pair of a burst; 0..15.

Ports:
- C, input, 1: the single clock. All logic is on the rising edge.
- R, input, 1: reset. Synchronous, active-high.
- DIN, input, WIDTH: word to serialize.
- DVALID, input, 1: DIN valid.
- DREADY, output, 1: word accepted on an edge where DVALID && DREADY.
- D0, output, 1: bit for the rising-edge DDR phase.
- D1, output, 1: bit for the falling-edge DDR phase.
- CE, output, 1: clock enable to the DDR flop.
- T, output, 1: tristate control, 1 = pad released.
- BUSY, output, 1: high while state ≠ IDLE.

## Operation
- **Hold register.** One-word hold register (hold_full flag).
  - DREADY = !hold_full && !R.
  - An accept sets hold_full.
  - A load into the shifter clears hold_full.
  - Accept and load never occur on the same edge, because DREADY is low while hold is full.
- **Bit order.** MSB first.
  - Beat k drives D0 = word[WIDTH-1-2k] and D1 = word[WIDTH-2-2k].
  - Each word takes WIDTH/2 beats.
- **FSM states:** IDLE, LEAD, SHIFT, TAIL.
- **IDLE.** T=1, CE=0, D0=D1=0.
  - hold_full → LEAD if LEAD>0.
  - hold_full → SHIFT (loading the shifter) if LEAD=0.
- **LEAD.** T=0, CE=1, D0=D1=0. Lasts LEAD cycles, then → SHIFT, loading the shifter from hold.
- **SHIFT.** T=0, CE=1, D0/D1 = current pair.
  - On the last-beat edge, if hold_full: load the next word and stay in SHIFT (gapless).
  - Otherwise → TAIL if TAIL>0, else → IDLE.
- **TAIL.** T=0, CE=1, D0=D1=0.
  - hold_full → SHIFT on the next edge, with no LEAD (the burst resumes).
  - After TAIL cycles with hold empty → IDLE.
- **Late word.** A word accepted on the same edge as the last beat is not bypassed.
  - At least one TAIL-state cycle is inserted before it shifts (driven zeros).
  - If TAIL=0, the FSM goes to IDLE and restarts with LEAD.
- **Counters.**
  - Beat counter: width clog2(WIDTH/2), wraps to 0 on each load.
  - LEAD/TAIL counter: 4 bits.
- **Reset.** R=1 at an edge resets everything:
  - T=1, CE=0, D0=D1=0, BUSY=0, state=IDLE, hold_full=0, counters=0.
  - DREADY is low during R.
  - Reset mid-burst discards in-flight and held words. T rises at that edge, with no TAIL.
- **DVALID while DREADY=0.** Ignored. DIN need not be held stable by this block.

## Timing
- **Accept to first data.** Word accepted at edge n, from IDLE:
  - LEAD≥1: T=0 after edge n+1; first data pair valid after edge n+1+LEAD.
  - LEAD=0: first data pair valid after edge n+1.
- **Last data to release.** Last pair driven for the cycle after edge m; T=1 after edge m+1+TAIL.
- **Sustained throughput.** One word per WIDTH/2 cycles. This requires each next word to be accepted no later than the edge before the current word's last-beat edge.
- **DREADY timing.** DREADY rises in the cycle after a load edge.
- **Output latency.** All outputs are registered; no combinational path from DIN/DVALID to D0/D1/T/CE.

## Structure
- Shared package/header holds:
  - the FSM state encodings (IDLE=0, LEAD=1, SHIFT=2, TAIL=3);
  - the LEAD/TAIL counter width constant.
- One natural sub-module, `word_hold_reg`: the one-entry hold register with its valid/ready logic, reusable by the matching input deserializer.
- The shifter, counters and FSM stay in the top module.

## Test plan
All scenarios use WIDTH=8, LEAD=1, TAIL=1 unless stated.
- **Single word.** Accept 0xB4 at edge n → T=0 from n+1; pairs (1,0),(1,1),(0,1),(0,0) after edges n+2..n+5; zeros with T=0 after n+6; T=1, BUSY=0 after n+7.
- **Back-to-back.** Words 0xFF then 0x00, second presented during the first word's beat 0 → 8 contiguous pairs, no zero gap, single LEAD and single TAIL.
- **Late word.** Second word accepted on the last-beat edge → exactly one driven-zero TAIL cycle, then SHIFT with no LEAD, T stays 0 throughout.
- **Backpressure.** Hold DVALID=1 with 4 distinct words → DREADY toggles, each word appears exactly once, in order, with no duplicates.
- **Reset mid-burst.** Assert R on beat 2 of 0xA5 → T=1, CE=0, D0=D1=0, DREADY=0 after that edge; a new word after reset starts a fresh LEAD.
- **Zero lead/tail.** LEAD=0, TAIL=0 → first pair after edge n+1; T=1 on the edge immediately after the last pair.
